osd_bitmap_writer: RTL
======================

OSD_BITMAP_WRITER -- requirements
Module: osd_bitmap_writer

Interface
REQ-001 Parameters SHALL be:
  - SCREEN_WIDTH, default 1920: bitmap width in pixels; multiple of 8.
  - SCREEN_HEIGHT, default 1080: bitmap height in pixels.
  - BITMAP_ADDR_WIDTH, default 18: width of the byte address into the bitmap RAM.
REQ-002 Ports SHALL be:
  - clk  in  1  the single clock.
  - resetn  in  1  asynchronous, active-low reset.
  - s_pixel_data  in  1  1-bit OSD pixel from the upstream char OSD stage.
  - s_pixel_valid  in  1  pixel valid.
  - s_pixel_ready  out  1  pixel accepted when valid and ready are both high.
  - s_pixel_posX  in  11  pixel X coordinate.
  - s_pixel_posY  in  11  pixel Y coordinate.
  - s_flush  in  1  single-cycle request to commit the pending byte.
  - ram_addr  out  BITMAP_ADDR_WIDTH  bitmap RAM byte address, shared by read and write.
  - ram_rd_en  out  1  read strobe; data returns on ram_dout the next cycle.
  - ram_dout  in  8  RAM read data.
  - ram_din  out  8  RAM write data.
  - ram_we  out  1  write strobe.
  - busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-003 Byte address SHALL be posY*(SCREEN_WIDTH/8) + posX[10:3], truncated to BITMAP_ADDR_WIDTH; bit index SHALL be posX[2:0], where bit0 is the leftmost pixel.
REQ-004 The block SHALL hold one pending byte: pend_addr, pend_bits[7:0] and pend_mask[7:0]; an accepted pixel SHALL set pend_mask[idx]=1 and pend_bits[idx]=s_pixel_data.
REQ-005 A second pixel to the same bit of the pending byte SHALL overwrite the earlier value (last wins).
REQ-006 FSM states SHALL be IDLE, ACCUM, RD and WR.
  - IDLE: no pending byte.
  - ACCUM: pending byte present.
  - RD: ram_rd_en=1 and ram_addr=pend_addr for exactly one cycle.
  - WR: ram_we=1, ram_addr=pend_addr, ram_din=(ram_dout & ~pend_mask) | (pend_bits & pend_mask) for exactly one cycle.
REQ-007 s_pixel_ready SHALL be combinational and equal:
  - 1 in IDLE;
  - 1 in ACCUM when s_flush=0 and either the incoming address equals pend_addr or the pixel is out of range;
  - 0 otherwise.
REQ-008 An accepted pixel with posX>=SCREEN_WIDTH or posY>=SCREEN_HEIGHT SHALL be dropped with no state change.
REQ-009 Transitions SHALL be:
  - IDLE->ACCUM on an accepted in-range pixel; pend_mask is loaded with only that bit.
  - ACCUM->RD when s_flush=1, or when s_pixel_valid=1 with an in-range pixel at a different address.
  - RD->WR unconditionally.
  - WR->IDLE unconditionally.
REQ-010 A mismatching pixel SHALL be held (ready=0) through ACCUM, RD and WR, then accepted in the following IDLE cycle; this gives 3 stall cycles per byte change.
REQ-011 s_flush SHALL be ignored in IDLE, RD and WR; s_flush together with a valid pixel in ACCUM SHALL flush first, with ready=0.
REQ-012 ram_rd_en and ram_we SHALL never both be high; each strobe is high for exactly one cycle per flush.
REQ-013 ram_addr SHALL hold its last value outside RD and WR; ram_din is don't-care when ram_we=0.
REQ-014 busy SHALL be 1 in ACCUM, RD and WR.

Reset
REQ-015 While resetn=0, the block SHALL drive state=IDLE, pend_addr=0, pend_bits=0, pend_mask=0, ram_addr=0, ram_din=0, ram_rd_en=0, ram_we=0, busy=0 and s_pixel_ready=0, all asynchronously.
REQ-016 Reset asserted in ACCUM, RD or WR SHALL discard the pending byte with no write.
REQ-017 After resetn deasserts, the first cycle SHALL present s_pixel_ready=1.

Verification
REQ-018 The bench SHALL cover the following scenarios:
  - 8 pixels at posY=0, posX=0..7, data=1,0,1,0,1,0,1,0 with RAM[0]=0xFF, then s_flush -> RD at addr 0, then WR with ram_din=0x55, then busy=0.
  - Pixels at (8,2)=1 then (16,2)=1, RAM all zero -> second pixel stalled 3 cycles; write addr 480+1=481 with ram_din=0x01; second pixel then pending at addr 482.
  - Single pixel at (3,0)=0 with RAM[0]=0xFF, then flush -> ram_din=0xF7; the other 7 bits are preserved.
  - Pixel at (1920,5) or (0,1080) -> accepted and dropped; no RAM strobe; busy stays 0.
  - Pixel at (5,0)=1 then (5,0)=0, then flush with RAM[0]=0x20 -> ram_din=0x00 (last wins).
  - Reset asserted in the RD cycle -> no ram_we pulse; all outputs return to their reset values immediately.

Source files
------------

// File: rtl/osd_bitmap_writer.sv
// Packs the 1-bit OSD pixel stream into bytes and read-modify-writes each
// finished byte into the bitmap RAM, preserving bits that were not touched.
module osd_bitmap_writer #(
    parameter int SCREEN_WIDTH      = 1920,
    parameter int SCREEN_HEIGHT     = 1080,
    parameter int BITMAP_ADDR_WIDTH = 18
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         s_pixel_data,
    input  logic                         s_pixel_valid,
    output logic                         s_pixel_ready,
    input  logic [10:0]                  s_pixel_posX,
    input  logic [10:0]                  s_pixel_posY,
    input  logic                         s_flush,
    output logic [BITMAP_ADDR_WIDTH-1:0] ram_addr,
    output logic                         ram_rd_en,
    input  logic [7:0]                   ram_dout,
    output logic [7:0]                   ram_din,
    output logic                         ram_we,
    output logic                         busy
);

    localparam int          BYTES_PER_LINE = SCREEN_WIDTH / 8;
    localparam logic [31:0] WIDTH_LIMIT    = 32'(SCREEN_WIDTH);
    localparam logic [31:0] HEIGHT_LIMIT   = 32'(SCREEN_HEIGHT);

    typedef enum logic [1:0] {IDLE, ACCUM, RD, WR} state_t;

    state_t                         state_q, state_d;
    logic [BITMAP_ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic [BITMAP_ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [7:0]                     pend_bits_q, pend_bits_d;
    logic [7:0]                     pend_mask_q, pend_mask_d;

    logic [BITMAP_ADDR_WIDTH-1:0]   in_addr;
    logic [7:0]                     in_onehot;
    logic                           in_range;
    logic                           same_addr;
    logic                           accept;

    // Truncating the operands first is equivalent to truncating the sum.
    always_comb begin
        in_addr   = BITMAP_ADDR_WIDTH'(s_pixel_posY) * BITMAP_ADDR_WIDTH'(BYTES_PER_LINE)
                  + BITMAP_ADDR_WIDTH'(s_pixel_posX[10:3]);
        in_onehot = 8'b1 << s_pixel_posX[2:0];
        in_range  = ({21'd0, s_pixel_posX} < WIDTH_LIMIT) &&
                    ({21'd0, s_pixel_posY} < HEIGHT_LIMIT);
        same_addr = (in_addr == pend_addr_q);
    end

    always_comb begin
        s_pixel_ready = 1'b0;
        if (resetn) begin
            case (state_q)
                IDLE:    s_pixel_ready = 1'b1;
                ACCUM:   s_pixel_ready = !s_flush && (same_addr || !in_range);
                default: s_pixel_ready = 1'b0;
            endcase
        end
    end

    assign accept = s_pixel_valid && s_pixel_ready;

    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        pend_bits_d = pend_bits_q;
        pend_mask_d = pend_mask_q;
        ram_addr_d  = ram_addr_q;
        case (state_q)
            IDLE: begin
                if (accept && in_range) begin
                    state_d     = ACCUM;
                    pend_addr_d = in_addr;
                    pend_mask_d = in_onehot;
                    pend_bits_d = s_pixel_data ? in_onehot : 8'h00;
                end
            end
            ACCUM: begin
                // A pixel for another byte waits here until the write-back completes.
                if (s_flush || (s_pixel_valid && in_range && !same_addr)) begin
                    state_d    = RD;
                    ram_addr_d = pend_addr_q;
                end else if (accept && in_range) begin
                    pend_mask_d = pend_mask_q | in_onehot;
                    pend_bits_d = (pend_bits_q & ~in_onehot) |
                                  (s_pixel_data ? in_onehot : 8'h00);
                end
            end
            RD: state_d = WR;
            WR: begin
                state_d     = IDLE;
                pend_bits_d = 8'h00;
                pend_mask_d = 8'h00;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            pend_addr_q <= '0;
            pend_bits_q <= 8'h00;
            pend_mask_q <= 8'h00;
            ram_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_bits_q <= pend_bits_d;
            pend_mask_q <= pend_mask_d;
            ram_addr_q  <= ram_addr_d;
        end
    end

    // RAM read data arrives during WR, so the merge has to be combinational there.
    assign ram_addr  = ram_addr_q;
    assign ram_rd_en = (state_q == RD);
    assign ram_we    = (state_q == WR);
    assign busy      = (state_q != IDLE);
    assign ram_din   = ram_we ? ((ram_dout & ~pend_mask_q) | (pend_bits_q & pend_mask_q)) : 8'h00;

endmodule
